// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS-31 stream checker with SEARCH/LOCKED FSM and saturating statistics.
// Define PRBS_CHECKER_BIT_ERR_EN to add the o_bit_err_count output and its popcount logic.
module prbs_checker #(
  parameter int C_LOCK_COUNT   = 4,
  parameter int C_UNLOCK_COUNT = 4,
  parameter int C_CNT_WIDTH    = 32
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_aresetn,
  input  logic                   i_enable,
  input  logic                   i_clear,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tvalid,
  input  logic [31:0]            s_axis_tdata,
  output logic                   o_locked,
  output logic [C_CNT_WIDTH-1:0] o_word_count,
  output logic [C_CNT_WIDTH-1:0] o_err_count,
`ifdef PRBS_CHECKER_BIT_ERR_EN
  output logic [C_CNT_WIDTH-1:0] o_bit_err_count,
`endif
  output logic [C_CNT_WIDTH-1:0] o_lock_loss
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0]             LOCK_N   = 4'(C_LOCK_COUNT);
  localparam logic [3:0]             UNLOCK_N = 4'(C_UNLOCK_COUNT);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = C_CNT_WIDTH'(1);

  // s[63:32] holds the previous word (s[63] earliest); each lower bit follows b[n]=b[n-31]^b[n-28].
  function automatic logic [31:0] prbs31_next(input logic [31:0] w);
    logic [63:0] s;
    s = {w, 32'h0};
    for (int k = 31; k >= 0; k--) s[k] = s[k+31] ^ s[k+28];
    return s[31:0];
  endfunction

  function automatic logic [C_CNT_WIDTH-1:0] sat_inc(input logic [C_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  state_t                 state_q, state_d;
  logic [31:0]            ref_q, ref_d;
  logic                   seeded_q, seeded_d;
  logic [3:0]             match_q, match_d;
  logic [3:0]             miss_q, miss_d;
  logic                   locked_q, locked_d;
  logic [C_CNT_WIDTH-1:0] word_q, word_d;
  logic [C_CNT_WIDTH-1:0] err_q, err_d;
  logic [C_CNT_WIDTH-1:0] loss_q, loss_d;
  logic                   accept;
  logic [31:0]            pred;
  logic                   mismatch;

  assign s_axis_tready = i_enable & s_axi_aresetn;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pred          = prbs31_next(ref_q);
  assign mismatch      = (s_axis_tdata != pred);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    seeded_d = seeded_q;
    match_d  = match_q;
    miss_d   = miss_q;
    word_d   = word_q;
    err_d    = err_q;
    loss_d   = loss_q;
    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d  = SEARCH;
          seeded_d = 1'b0;
          match_d  = '0;
          miss_d   = '0;
        end
      end
      SEARCH: begin
        if (accept) begin
          ref_d    = s_axis_tdata;
          seeded_d = 1'b1;
          if (seeded_q) begin
            // An all-zero word is a PRBS fixed point, so it must never count towards lock.
            if (!mismatch && (s_axis_tdata != 32'h0)) begin
              match_d = match_q + 4'd1;
              if (match_q + 4'd1 == LOCK_N) begin
                state_d = LOCKED;
                miss_d  = '0;
              end
            end else begin
              match_d = '0;
            end
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          ref_d  = pred;
          word_d = sat_inc(word_q);
          if (mismatch) begin
            err_d  = sat_inc(err_q);
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == UNLOCK_N) begin
              state_d  = SEARCH;
              loss_d   = sat_inc(loss_q);
              match_d  = '0;
              miss_d   = '0;
              seeded_d = 1'b0;
            end
          end else begin
            miss_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!i_enable) state_d = IDLE;
    if (i_clear) begin
      word_d = '0;
      err_d  = '0;
      loss_d = '0;
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      seeded_q <= 1'b0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      word_q   <= '0;
      err_q    <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      seeded_q <= seeded_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      word_q   <= word_d;
      err_q    <= err_d;
      loss_q   <= loss_d;
    end
  end

  assign o_locked     = locked_q;
  assign o_word_count = word_q;
  assign o_err_count  = err_q;
  assign o_lock_loss  = loss_q;

`ifdef PRBS_CHECKER_BIT_ERR_EN
  logic [C_CNT_WIDTH-1:0] bit_q, bit_d;
  logic [31:0]            diff;
  logic [5:0]             pop;
  logic [C_CNT_WIDTH:0]   bit_sum;

  assign diff = s_axis_tdata ^ pred;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 32; i++) pop = pop + 6'(diff[i]);
    bit_sum = {1'b0, bit_q} + (C_CNT_WIDTH+1)'(pop);
    bit_d   = bit_q;
    if (accept && (state_q == LOCKED)) bit_d = bit_sum[C_CNT_WIDTH] ? '1 : bit_sum[C_CNT_WIDTH-1:0];
    if (i_clear) bit_d = '0;
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) bit_q <= '0;
    else                bit_q <= bit_d;
  end

  assign o_bit_err_count = bit_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - self-checking bench for prbs_checker: vector table, corner sequences, random gaps/errors.
module tb_prbs_checker;
  localparam int LOCK = 4, UNLOCK = 4, CW = 32, NG = 1300;

  logic          clk = 1'b0;
  logic          resetn = 1'b0, enable = 1'b0, clear = 1'b0, tvalid = 1'b0;
  logic [31:0]   tdata = '0;
  logic          tready, locked;
  logic [CW-1:0] words, errs, loss;
`ifdef PRBS_CHECKER_BIT_ERR_EN
  logic [CW-1:0] bit_errs;
`endif
  int passed = 0, total = 0;
  logic [31:0] gold [NG];

  always #5 clk = ~clk;

  prbs_checker #(.C_LOCK_COUNT(LOCK), .C_UNLOCK_COUNT(UNLOCK), .C_CNT_WIDTH(CW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(resetn), .i_enable(enable), .i_clear(clear),
    .s_axis_tready(tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
    .o_locked(locked), .o_word_count(words), .o_err_count(errs),
`ifdef PRBS_CHECKER_BIT_ERR_EN
    .o_bit_err_count(bit_errs),
`endif
    .o_lock_loss(loss)
  );

  typedef struct {
    int          idx;
    logic [31:0] flip;
    bit          zero;
    bit          clr;
    bit          exp_locked;
    int          exp_words;
    int          exp_errs;
    int          exp_loss;
    int          exp_bits;
  } vec_t;
  vec_t tbl [25];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    else passed++;
  endtask

  task automatic beat(input logic v, input logic [31:0] d, input logic clr);
    @(negedge clk);
    tvalid = v; tdata = d; clear = clr;
    @(posedge clk);
    #1;
    tvalid = 1'b0; clear = 1'b0;
  endtask

  task automatic tv(input int i, input int idx, input logic [31:0] flip, input bit zero, input bit clr,
                    input bit lk, input int w, input int e, input int l, input int b);
    tbl[i] = '{idx, flip, zero, clr, lk, w, e, l, b};
  endtask

  task automatic chk_counts(input string tag, input bit lk, input int w, input int e, input int l);
    chk({tag, "_locked"}, 64'(locked), 64'(lk));
    chk({tag, "_words"}, 64'(words), 64'(w));
    chk({tag, "_errs"}, 64'(errs), 64'(e));
    chk({tag, "_loss"}, 64'(loss), 64'(l));
  endtask

  initial begin
    bit gb [];
    logic [31:0] seed, d, m;
    int b, consec, exp_w, exp_e;
    longint exp_b;

    // Golden PRBS-31 bit stream from the recurrence, packed earliest bit into bit 31.
    seed = 32'h7FFF_FFFF;
    gb = new[NG*32];
    for (int j = 0; j < 32; j++) gb[j] = seed[31-j];
    for (int n = 32; n < NG*32; n++) gb[n] = gb[n-31] ^ gb[n-28];
    for (int w = 0; w < NG; w++)
      for (int j = 0; j < 32; j++) gold[w][31-j] = gb[32*w+j];

    for (int i = 0; i < 4; i++) tv(i, i, 0, 0, 0, 0, 0, 0, 0, 0);
    tv(4, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    tv(5, 5, 0, 0, 0, 1, 1, 0, 0, 0);
    tv(6, 6, 32'h1, 0, 0, 1, 2, 1, 0, 1);
    tv(7, 7, 0, 0, 0, 1, 3, 1, 0, 1);
    b = 1;
    for (int k = 0; k < 4; k++) begin
      b += $countones(gold[8+k]);
      tv(8+k, 8+k, 0, 1, 0, k < 3, 4+k, 2+k, (k == 3) ? 1 : 0, b);
    end
    for (int k = 12; k < 18; k++) tv(k, 0, 0, 1, 0, 0, 7, 5, 1, b);
    for (int k = 0; k < 5; k++) tv(18+k, 20+k, 0, 0, 0, k == 4, 7, 5, 1, b);
    tv(23, 25, 32'hF0, 0, 1, 1, 0, 0, 0, 0);
    tv(24, 26, 0, 0, 0, 1, 1, 0, 0, 0);

    // Reset state, ready masked while in reset.
    repeat (2) @(posedge clk);
    #1;
    chk_counts("reset", 0, 0, 0, 0);
    @(negedge clk);
    enable = 1'b1;
    #1;
    chk("tready_in_reset", 64'(tready), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_enabled", 64'(tready), 64'd1);

    for (int i = 0; i < 25; i++) begin
      d = tbl[i].zero ? 32'h0 : (gold[tbl[i].idx] ^ tbl[i].flip);
      beat(1'b1, d, tbl[i].clr);
      chk_counts($sformatf("vec%0d", i), tbl[i].exp_locked, tbl[i].exp_words, tbl[i].exp_errs, tbl[i].exp_loss);
`ifdef PRBS_CHECKER_BIT_ERR_EN
      chk($sformatf("vec%0d_bits", i), 64'(bit_errs), 64'(tbl[i].exp_bits));
`endif
    end

    // Disable drops to IDLE with counters held; re-enable must relock from scratch.
    @(negedge clk);
    enable = 1'b0;
    #1;
    chk("tready_disabled", 64'(tready), 64'd0);
    @(posedge clk);
    #1;
    chk_counts("disable", 0, 1, 0, 0);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    #1;
    beat(1'b0, $urandom, 1'b1);
    chk_counts("clear_idle_beat", 0, 0, 0, 0);

    // 1000 golden words with random valid gaps: lock after the 5th, every later word counted clean.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(1) == 0) beat(1'b0, $urandom, 1'b0);
      beat(1'b1, gold[100+i], 1'b0);
    end
    chk_counts("golden1000", 1, 1000 - LOCK - 1, 0, 0);

    // Sparse random corruption, never UNLOCK consecutive errors, so lock holds.
    consec = 0; exp_w = 1000 - LOCK - 1; exp_e = 0; exp_b = 0;
    for (int i = 0; i < 150; i++) begin
      d = gold[1100+i];
      if (consec < UNLOCK - 1 && $urandom_range(3) == 0) begin
        m = $urandom;
        if (m == 0) m = 32'h1;
        d = d ^ m;
        exp_e++;
        exp_b += $countones(m);
        consec++;
      end else begin
        consec = 0;
      end
      exp_w++;
      if ($urandom_range(1) == 0) beat(1'b0, $urandom, 1'b0);
      beat(1'b1, d, 1'b0);
    end
    chk_counts("random_err", 1, exp_w, exp_e, 0);
`ifdef PRBS_CHECKER_BIT_ERR_EN
    chk("random_err_bits", 64'(bit_errs), 64'(exp_b));
`endif

    // Reset while locked clears everything; relock needs the full match count.
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("tready_mid_reset", 64'(tready), 64'd0);
    @(posedge clk);
    #1;
    chk_counts("reset_locked", 0, 0, 0, 0);
`ifdef PRBS_CHECKER_BIT_ERR_EN
    chk("reset_locked_bits", 64'(bit_errs), 64'd0);
`endif
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      beat(1'b1, gold[k], 1'b0);
      chk($sformatf("relock%0d", k), 64'(locked), 64'(k == 4));
    end
    chk("relock_words", 64'(words), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
